// File: rtl/dmem_rv64_param.sv
// dmem_rv64_param: byte-addressed RV64 data memory, valid/ready request, registered response.
// Define DMEM_MISALIGN_SPLIT_EN to split word-crossing misaligned accesses into two beats.
module dmem_rv64_param #(
  parameter int XLEN   = 64,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault
);

  localparam int IW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 8);

`ifdef DMEM_MISALIGN_SPLIT_EN
  typedef enum logic {IDLE, SPLIT} state_e;
`else
  typedef enum logic {IDLE} state_e;
`endif

  function automatic logic [XLEN-1:0] ext(
    input logic [XLEN-1:0] r,
    input logic [2:0]      f
  );
    logic [XLEN-1:0] v;
    v = '0;
    unique case (f)
      3'b000:  v = {{(XLEN-8){r[7]}}, r[7:0]};
      3'b001:  v = {{(XLEN-16){r[15]}}, r[15:0]};
      3'b010:  v = {{(XLEN-32){r[31]}}, r[31:0]};
      3'b011:  v = r;
      3'b100:  v = {{(XLEN-8){1'b0}}, r[7:0]};
      3'b101:  v = {{(XLEN-16){1'b0}}, r[15:0]};
      3'b110:  v = {{(XLEN-32){1'b0}}, r[31:0]};
      default: v = '0;
    endcase
    return v;
  endfunction

  logic [XLEN-1:0] mem_q [DEPTH];
  state_e          state_q, state_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_fault_q, rsp_fault_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [IW-1:0]   widx;
  logic [2:0]      off;
  logic [5:0]      sh;
  logic [3:0]      size;
  logic [NB-1:0]   bmask;
  logic            bad_f3, oor, fault, accept;
  logic            wr_en, rd_en;
  logic [IW-1:0]   wr_idx;
  logic [NB-1:0]   wr_mask;
  logic [XLEN-1:0] wr_data, raw;
  logic [2:0]      rd_f3;

  assign widx      = req_addr[IW+2:3];
  assign off       = req_addr[2:0];
  assign sh        = {off, 3'b000};
  assign size      = 4'd1 << req_funct3[1:0];
  assign bmask     = NB'((9'd1 << size) - 9'd1);
  assign bad_f3    = (&req_funct3) | (req_we & req_funct3[2]);
  assign oor       = {1'b0, req_addr} >= LIMIT;
  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic              cross, split;
  logic [2*NB-1:0]   wm;
  logic [2*XLEN-1:0] wd, win;
  logic [IW-1:0]     idx_q;
  logic [2:0]        off_q, f3_q;
  logic              we_q;
  logic [NB-1:0]     wm_hi_q;
  logic [XLEN-1:0]   wd_hi_q, lo_q;

  assign cross = ({1'b0, off} + size) > 4'd8;
  assign fault = bad_f3 | oor | (cross & (&widx));
  assign split = accept & ~fault & cross;
  assign wm    = {{NB{1'b0}}, bmask} << off;
  assign wd    = {{XLEN{1'b0}}, req_wdata} << sh;
  assign win   = {mem_q[idx_q + IW'(1)], lo_q} >> {off_q, 3'b000};

  always_comb begin
    state_d     = state_q;
    wr_en       = accept & ~fault & req_we;
    wr_idx      = widx;
    wr_mask     = wm[NB-1:0];
    wr_data     = wd[XLEN-1:0];
    raw         = mem_q[widx] >> sh;
    rd_f3       = req_funct3;
    rd_en       = accept & ~fault & ~req_we & ~split;
    rsp_valid_d = accept & ~split;
    rsp_fault_d = accept & fault;
    unique case (state_q)
      IDLE: if (split) state_d = SPLIT;
      SPLIT: begin
        // second beat: upper word of the latched crossing access
        state_d     = IDLE;
        wr_en       = we_q;
        wr_idx      = idx_q + IW'(1);
        wr_mask     = wm_hi_q;
        wr_data     = wd_hi_q;
        raw         = win[XLEN-1:0];
        rd_f3       = f3_q;
        rd_en       = ~we_q;
        rsp_valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wm_hi_q <= '0;
      wd_hi_q <= '0;
      lo_q    <= '0;
    end else if (split) begin
      idx_q   <= widx;
      off_q   <= off;
      f3_q    <= req_funct3;
      we_q    <= req_we;
      wm_hi_q <= wm[2*NB-1:NB];
      wd_hi_q <= wd[2*XLEN-1:XLEN];
      lo_q    <= mem_q[widx];
    end
  end
`else
  assign fault = bad_f3 | oor | (({1'b0, off} & (size - 4'd1)) != 4'd0);

  always_comb begin
    state_d     = IDLE;
    wr_en       = accept & ~fault & req_we;
    wr_idx      = widx;
    wr_mask     = bmask << off;
    wr_data     = req_wdata << sh;
    raw         = mem_q[widx] >> sh;
    rd_f3       = req_funct3;
    rd_en       = accept & ~fault & ~req_we;
    rsp_valid_d = accept;
    rsp_fault_d = accept & fault;
  end
`endif

  always_comb rsp_rdata_d = rd_en ? ext(raw, rd_f3) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (wr_mask[b]) mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
